// File: rtl/eth_rx_buf_wr_pkg.sv
// Shared definitions for the Ethernet receive-buffer writer: FSM encoding,
// default buffer geometry and the byte-capacity helper.
package eth_rx_buf_wr_pkg;

  localparam int ETH_ADDR_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ETH_CAPACITY = 4 << ETH_ADDR_W;

  function automatic int unsigned capacity(input int unsigned addr_w);
    return 32'd4 << addr_w;
  endfunction

endpackage

// File: rtl/eth_word_packer.sv
// Little-endian byte-lane accumulator. The word/strobes outputs already
// include the byte being loaded this cycle, so a write can be registered directly.
module eth_word_packer
  import eth_rx_buf_wr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_byte,
  input  logic [1:0]  lane,
  input  logic        load,
  input  logic        clear,
  output logic [31:0] word,
  output logic [3:0]  strobes
);

  logic [31:0] acc_q;
  logic [3:0]  strb_q;

  always_comb begin
    word    = acc_q;
    strobes = strb_q;
    if (load) begin
      word[{lane, 3'b000} +: 8] = data_byte;
      strobes[lane]             = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      strb_q <= '0;
    end else if (clear) begin
      acc_q  <= '0;
      strb_q <= '0;
    end else if (load) begin
      acc_q  <= word;
      strb_q <= strobes;
    end
  end

endmodule

// File: rtl/eth_rx_buf_wr.sv
// RX MAC byte stream to 32-bit byte-strobed buffer writes; holds the finished
// frame (length, error flag) until the CPU acknowledges it.
module eth_rx_buf_wr
  import eth_rx_buf_wr_pkg::*;
#(
  parameter int ADDR_W = ETH_ADDR_W,
  parameter int LEN_W  = ADDR_W + 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_last,
  input  logic              rx_err,
  input  logic              rcv_ack,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic [3:0]        mem_wstrb,
  output logic              mem_we,
  output logic              frame_rdy,
  output logic [LEN_W-1:0]  frame_len,
  output logic              frame_err
);

  localparam logic [LEN_W-1:0] CAP = LEN_W'(capacity(ADDR_W));

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q;
  logic              accept, full, store, fire, to_idle;
  logic [1:0]        lane;
  logic [31:0]       pk_word;
  logic [3:0]        pk_strobes;

  assign rx_ready  = (state_q != DONE);
  assign accept    = rx_valid & rx_ready;
  assign full      = (cnt_q == CAP);
  assign store     = accept & ~full;
  assign lane      = cnt_q[1:0];
  assign fire      = store & ((lane == 2'b11) | rx_last);
  assign to_idle   = (state_q == DONE) & rcv_ack;
  assign frame_len = cnt_q;

  eth_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .data_byte (rx_data),
    .lane      (lane),
    .load      (store),
    .clear     (fire | to_idle),
    .word      (pk_word),
    .strobes   (pk_strobes)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = rx_last ? DONE : RECV;
      RECV: if (accept && rx_last) state_d = DONE;
      DONE: if (rcv_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter stops at capacity; later bytes are dropped and only flag an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      frame_err <= 1'b0;
      frame_rdy <= 1'b0;
    end else begin
      if (to_idle) begin
        cnt_q <= '0;
      end else if (store) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end

      if (to_idle) begin
        frame_err <= 1'b0;
      end else if (accept && (rx_err || full)) begin
        frame_err <= 1'b1;
      end

      // One cycle behind DONE entry so the final write lands before the CPU sees it.
      frame_rdy <= (state_q == DONE) & ~rcv_ack;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_wstrb <= '0;
    end else begin
      mem_we <= fire;
      if (fire) begin
        mem_addr  <= cnt_q[ADDR_W+1:2];
        mem_data  <= pk_word;
        mem_wstrb <= pk_strobes;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_buf_wr.sv
// Directed self-checking bench for eth_rx_buf_wr at the default geometry.
module tb_eth_rx_buf_wr;

  localparam int ADDR_W = 9;
  localparam int LEN_W  = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid, rx_last, rx_err, rcv_ack;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic [3:0]        mem_wstrb;
  logic              mem_we;
  logic              frame_rdy;
  logic [LEN_W-1:0]  frame_len;
  logic              frame_err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [8:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;
  wr_t wr_q[$];

  eth_rx_buf_wr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_last   (rx_last),
    .rx_err    (rx_err),
    .rcv_ack   (rcv_ack),
    .rx_ready  (rx_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_wstrb (mem_wstrb),
    .mem_we    (mem_we),
    .frame_rdy (frame_rdy),
    .frame_len (frame_len),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_data, mem_wstrb});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic err);
    rx_data  = d;
    rx_valid = 1'b1;
    rx_last  = last;
    rx_err   = err;
    tick();
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic ack();
    rcv_ack = 1'b1;
    tick();
    rcv_ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%0h exp=0", mem_we); end
    checks++; if ({mem_addr, mem_data, mem_wstrb} !== '0) begin errors++; $display("FAIL reset_mem got=%0h/%0h/%0h exp=0", mem_addr, mem_data, mem_wstrb); end
    checks++; if ({frame_rdy, frame_len, frame_err} !== '0) begin errors++; $display("FAIL reset_frame got=%0h/%0h/%0h exp=0", frame_rdy, frame_len, frame_err); end
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0h exp=1", rx_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    wr_q.delete();
    for (int i = 1; i <= 7; i++) send(8'(i), 1'b0, 1'b0);
    send(8'h08, 1'b1, 1'b0);
    checks++; if ({mem_we, frame_rdy} !== 2'b10) begin errors++; $display("FAIL b2b_t1 we/rdy got=%b exp=10", {mem_we, frame_rdy}); end
    tick();
    checks++; if ({mem_we, frame_rdy} !== 2'b01) begin errors++; $display("FAIL b2b_t2 we/rdy got=%b exp=01", {mem_we, frame_rdy}); end
    checks++; if (wr_q.size() != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", wr_q.size()); end
    checks++; if (wr_q[0] !== {9'd0, 32'h04030201, 4'hF}) begin errors++; $display("FAIL b2b_wr0 got=%h exp=%h", wr_q[0], {9'd0, 32'h04030201, 4'hF}); end
    checks++; if (wr_q[1] !== {9'd1, 32'h08070605, 4'hF}) begin errors++; $display("FAIL b2b_wr1 got=%h exp=%h", wr_q[1], {9'd1, 32'h08070605, 4'hF}); end
    checks++; if ({frame_len, frame_err} !== {12'd8, 1'b0}) begin errors++; $display("FAIL b2b_len_err got=%0d/%0d exp=8/0", frame_len, frame_err); end
    ack();
    checks++; if ({frame_rdy, frame_len, rx_ready} !== {1'b0, 12'd0, 1'b1}) begin errors++; $display("FAIL b2b_ack rdy/len/ready got=%0d/%0d/%0d exp=0/0/1", frame_rdy, frame_len, rx_ready); end
  endtask

  task automatic test_gaps();
    wr_q.delete();
    for (int i = 0; i < 5; i++) begin
      send(8'hA0 + 8'(i), (i == 4), 1'b0);
      if (i < 4) repeat (2) tick();
    end
    tick();
    checks++; if (wr_q.size() != 2) begin errors++; $display("FAIL gaps_count got=%0d exp=2", wr_q.size()); end
    checks++; if (wr_q[0] !== {9'd0, 32'hA3A2A1A0, 4'hF}) begin errors++; $display("FAIL gaps_wr0 got=%h exp=%h", wr_q[0], {9'd0, 32'hA3A2A1A0, 4'hF}); end
    checks++; if ({wr_q[1].a, wr_q[1].d[7:0], wr_q[1].s} !== {9'd1, 8'hA4, 4'h1}) begin errors++; $display("FAIL gaps_wr1 got=%0h/%0h/%0h exp=1/a4/1", wr_q[1].a, wr_q[1].d[7:0], wr_q[1].s); end
    checks++; if ({frame_rdy, frame_len} !== {1'b1, 12'd5}) begin errors++; $display("FAIL gaps_len got=%0d/%0d exp=1/5", frame_rdy, frame_len); end
    ack();
  endtask

  task automatic test_single();
    wr_q.delete();
    send(8'h55, 1'b1, 1'b0);
    checks++; if ({mem_we, frame_rdy} !== 2'b10) begin errors++; $display("FAIL single_t1 we/rdy got=%b exp=10", {mem_we, frame_rdy}); end
    tick();
    checks++; if ({mem_we, frame_rdy} !== 2'b01) begin errors++; $display("FAIL single_t2 we/rdy got=%b exp=01", {mem_we, frame_rdy}); end
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", wr_q.size()); end
    checks++; if ({wr_q[0].a, wr_q[0].d[7:0], wr_q[0].s} !== {9'd0, 8'h55, 4'h1}) begin errors++; $display("FAIL single_wr got=%0h/%0h/%0h exp=0/55/1", wr_q[0].a, wr_q[0].d[7:0], wr_q[0].s); end
    checks++; if (frame_len !== 12'd1) begin errors++; $display("FAIL single_len got=%0d exp=1", frame_len); end
    ack();
  endtask

  task automatic test_overflow();
    int bad;
    logic [31:0] exp_d;
    wr_q.delete();
    for (int n = 0; n < 2050; n++) send(8'(n), (n == 2049), 1'b0);
    tick();
    checks++; if (wr_q.size() != 512) begin errors++; $display("FAIL ovf_count got=%0d exp=512", wr_q.size()); end
    bad = 0;
    for (int k = 0; k < wr_q.size(); k++) begin
      exp_d = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      if (wr_q[k] !== {9'(k), exp_d, 4'hF}) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ovf_words bad=%0d exp=0", bad); end
    checks++; if ({frame_rdy, frame_len, frame_err} !== {1'b1, 12'd2048, 1'b1}) begin errors++; $display("FAIL ovf_frame got=%0d/%0d/%0d exp=1/2048/1", frame_rdy, frame_len, frame_err); end
    ack();
  endtask

  task automatic test_done_drop();
    wr_q.delete();
    send(8'hC1, 1'b0, 1'b0);
    send(8'hC2, 1'b1, 1'b0);
    tick();
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL drop_ready got=%0d exp=0", rx_ready); end
    send(8'hE0, 1'b0, 1'b0);
    send(8'hE1, 1'b0, 1'b1);
    send(8'hE2, 1'b1, 1'b0);
    tick();
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL drop_count got=%0d exp=1", wr_q.size()); end
    checks++; if ({wr_q[0].a, wr_q[0].d[15:0], wr_q[0].s} !== {9'd0, 16'hC2C1, 4'h3}) begin errors++; $display("FAIL drop_wr got=%0h/%0h/%0h exp=0/c2c1/3", wr_q[0].a, wr_q[0].d[15:0], wr_q[0].s); end
    checks++; if ({frame_rdy, frame_len, frame_err} !== {1'b1, 12'd2, 1'b0}) begin errors++; $display("FAIL drop_frame got=%0d/%0d/%0d exp=1/2/0", frame_rdy, frame_len, frame_err); end
    ack();
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b1, 1'b0);
    tick();
    checks++; if (wr_q.size() != 2) begin errors++; $display("FAIL drop_next_count got=%0d exp=2", wr_q.size()); end
    checks++; if ({wr_q[1].a, wr_q[1].d[23:0], wr_q[1].s} !== {9'd0, 24'h332211, 4'h7}) begin errors++; $display("FAIL drop_next_wr got=%0h/%0h/%0h exp=0/332211/7", wr_q[1].a, wr_q[1].d[23:0], wr_q[1].s); end
    checks++; if (frame_len !== 12'd3) begin errors++; $display("FAIL drop_next_len got=%0d exp=3", frame_len); end
    ack();
  endtask

  task automatic test_reset_mid();
    wr_q.delete();
    send(8'h31, 1'b0, 1'b0);
    send(8'h32, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL rstmid_nowrite got=%0d exp=0", wr_q.size()); end
    checks++; if ({mem_we, mem_addr, mem_data, mem_wstrb} !== '0) begin errors++; $display("FAIL rstmid_mem got=%0h/%0h/%0h/%0h exp=0", mem_we, mem_addr, mem_data, mem_wstrb); end
    checks++; if ({frame_rdy, frame_len, frame_err, rx_ready} !== {15'd0, 1'b1}) begin errors++; $display("FAIL rstmid_frame got=%0d/%0d/%0d/%0d exp=0/0/0/1", frame_rdy, frame_len, frame_err, rx_ready); end
    rst = 1'b0;
    tick();
    send(8'h40, 1'b0, 1'b0);
    send(8'h41, 1'b0, 1'b0);
    send(8'h42, 1'b0, 1'b1);
    send(8'h43, 1'b1, 1'b0);
    tick();
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL rstmid_count got=%0d exp=1", wr_q.size()); end
    checks++; if (wr_q[0] !== {9'd0, 32'h43424140, 4'hF}) begin errors++; $display("FAIL rstmid_wr got=%h exp=%h", wr_q[0], {9'd0, 32'h43424140, 4'hF}); end
    checks++; if ({frame_rdy, frame_len, frame_err} !== {1'b1, 12'd4, 1'b1}) begin errors++; $display("FAIL rstmid_frame2 got=%0d/%0d/%0d exp=1/4/1", frame_rdy, frame_len, frame_err); end
    ack();
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = '0;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_err   = 1'b0;
    rcv_ack  = 1'b0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_single();
    test_overflow();
    test_done_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
